centroid_div_scheduler: RTL and testbench

Frame-level controller for the green-pixel centroid datapath. It takes the per-frame sums of green-pixel coordinates and the green-pixel count from the accumulator, snapshots them at each frame boundary, and clears the accumulator. It then time-shares one sequential divider between the X and Y quotients and publishes a registered centroid with a one-cycle valid strobe. It sits between the pixel accumulator and the overlay/marker logic that consumes `centro_x`/`centro_y`.

---
 rtl/centroid_pkg.sv | 16 +
 rtl/centroid_div_scheduler_if.sv | 37 +++
 rtl/centroid_div_scheduler_divider.sv | 81 ++++++++
 rtl/centroid_div_scheduler.sv | 148 ++++++++++++++
 tb/tb_centroid_div_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/centroid_pkg.sv
// Shared widths and scheduler state encoding
// for the green-pixel centroid datapath.
package centroid_pkg;

  localparam int COORD_W = 10;
  localparam int SUM_W   = 29;
  localparam int CNT_W   = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_X   = 2'd1,
    DIV_Y   = 2'd2,
    PUBLISH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/centroid_div_scheduler_if.sv
// Accumulator-side inputs and centroid outputs
// of the centroid scheduler.
interface centroid_div_scheduler_if
  import centroid_pkg::*;
#(
  parameter int COORD_W = centroid_pkg::COORD_W,
  parameter int SUM_W   = centroid_pkg::SUM_W,
  parameter int CNT_W   = centroid_pkg::CNT_W
);

  logic               enable;
  logic               frame_end;
  logic [SUM_W-1:0]   sum_x_in;
  logic [SUM_W-1:0]   sum_y_in;
  logic [CNT_W-1:0]   count_in;
  logic               acc_clear;
  logic [COORD_W-1:0] centro_x;
  logic [COORD_W-1:0] centro_y;
  logic               centro_valid;
  logic               busy;
  logic               frame_dropped;

  modport master (
    output enable, frame_end,
    output sum_x_in, sum_y_in, count_in,
    input  acc_clear, centro_x, centro_y,
    input  centro_valid, busy, frame_dropped
  );

  modport slave (
    input  enable, frame_end,
    input  sum_x_in, sum_y_in, count_in,
    output acc_clear, centro_x, centro_y,
    output centro_valid, busy, frame_dropped
  );

endinterface

// File: rtl/centroid_div_scheduler_divider.sv
// Restoring divider, one quotient bit per cycle;
// the start cycle performs the first iteration.
module seq_divider #(
  parameter int N_W = 29,
  parameter int D_W = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [N_W-1:0] dividend_i,
  input  logic [D_W-1:0] divisor_i,
  output logic [N_W-1:0] quotient_o,
  output logic           done_o
);

  localparam int CW = $clog2(N_W + 1);

  logic [D_W-1:0] rem_q, rem_d;
  logic [N_W-1:0] quo_q, quo_d;
  logic [D_W-1:0] div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  logic [D_W-1:0] rem_src;
  logic [N_W-1:0] quo_src;
  logic [D_W-1:0] dvs;
  logic [D_W:0]   shifted;
  logic           ge;

  always_comb begin
    rem_src = start_i ? '0 : rem_q;
    quo_src = start_i ? dividend_i : quo_q;
    dvs     = start_i ? divisor_i : div_q;
    shifted = {rem_src, quo_src[N_W-1]};
    ge      = shifted >= {1'b0, dvs};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (abort_i) begin
      cnt_d = '0;
    end else if (start_i || cnt_q != '0) begin
      rem_d = ge ? D_W'(shifted - {1'b0, dvs})
                 : shifted[D_W-1:0];
      quo_d = {quo_src[N_W-2:0], ge};
      div_d = dvs;
      if (start_i) begin
        cnt_d  = CW'(N_W - 1);
        done_d = (N_W == 1);
      end else begin
        cnt_d  = cnt_q - 1'b1;
        done_d = (cnt_q == CW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;

endmodule

// File: rtl/centroid_div_scheduler.sv
// Frame-boundary snapshot and shared-divider centroid scheduler.
// Optional CENTROID_ROUND_EN selects round-half-up quotients.
module centroid_div_scheduler
  import centroid_pkg::*;
#(
  parameter int COORD_W = centroid_pkg::COORD_W,
  parameter int SUM_W   = centroid_pkg::SUM_W,
  parameter int CNT_W   = centroid_pkg::CNT_W
) (
  input logic clk,
  input logic rst_n,
  centroid_div_scheduler_if.slave bus
);

  sched_state_t state_q, state_d;

  logic [SUM_W-1:0]   sum_y_q, sum_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [COORD_W-1:0] qx_q, qx_d;
  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;
  logic               valid_q, valid_d;
  logic               clr_q, clr_d;
  logic               drop_q, drop_d;

  logic               en;
  logic               fe;
  logic [SUM_W-1:0]   src_sum;
  logic [CNT_W-1:0]   src_cnt;
  logic [SUM_W:0]     dvd_w;
  logic               div_start;
  logic               div_done;
  logic [SUM_W-1:0]   quo;
  logic [COORD_W-1:0] q_sat;

  assign en = bus.enable;
  assign fe = bus.frame_end;

  // X starts straight from the inputs; Y from the snapshot
  assign src_sum = (state_q == IDLE) ? bus.sum_x_in : sum_y_q;
  assign src_cnt = (state_q == IDLE) ? bus.count_in : cnt_q;

`ifdef CENTROID_ROUND_EN
  assign dvd_w = {1'b0, src_sum} + (SUM_W+1)'(src_cnt >> 1);
`else
  assign dvd_w = {1'b0, src_sum};
`endif

  assign div_start = en &&
    ((state_q == IDLE && fe && bus.count_in != '0) ||
     (state_q == DIV_X && div_done));

  // A carried dividend is >= 2^SUM_W, so the quotient overflows too
  assign q_sat = (ovf_q || |quo[SUM_W-1:COORD_W])
               ? '1 : quo[COORD_W-1:0];

  seq_divider #(
    .N_W(SUM_W),
    .D_W(CNT_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .abort_i    (!en),
    .dividend_i (dvd_w[SUM_W-1:0]),
    .divisor_i  (src_cnt),
    .quotient_o (quo),
    .done_o     (div_done)
  );

  always_comb begin
    state_d = state_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    ovf_d   = div_start ? dvd_w[SUM_W] : ovf_q;
    qx_d    = qx_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = 1'b0;
    clr_d   = 1'b0;
    drop_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cx_d    = '0;
      cy_d    = '0;
      clr_d   = 1'b1;
    end else begin
      if (fe) begin
        clr_d  = 1'b1;
        drop_d = (state_q != IDLE);
      end
      unique case (state_q)
        IDLE: if (fe) begin
          sum_y_d = bus.sum_y_in;
          cnt_d   = bus.count_in;
          if (bus.count_in != '0) state_d = DIV_X;
        end
        DIV_X: if (div_done) begin
          qx_d    = q_sat;
          state_d = DIV_Y;
        end
        DIV_Y: if (div_done) begin
          cx_d    = qx_q;
          cy_d    = q_sat;
          valid_d = 1'b1;
          state_d = PUBLISH;
        end
        PUBLISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_y_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      qx_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_y_q <= sum_y_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      qx_q    <= qx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      clr_q   <= clr_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.acc_clear     = clr_q;
  assign bus.centro_x      = cx_q;
  assign bus.centro_y      = cy_q;
  assign bus.centro_valid  = valid_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.frame_dropped = drop_q;

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Directed bench for centroid_div_scheduler:
// timing, drop, rounding, saturation, enable and reset.
module tb_centroid_div_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  centroid_div_scheduler_if bus();

  centroid_div_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame pulse in cycle T; returns at the sampling point of T+1
  task automatic pulse_frame(
    input logic [28:0] sx,
    input logic [28:0] sy,
    input logic [18:0] c
  );
    @(negedge clk);
    bus.sum_x_in  = sx;
    bus.sum_y_in  = sy;
    bus.count_in  = c;
    bus.frame_end = 1'b1;
    @(negedge clk);
    bus.frame_end = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.frame_end = i[0];
      bus.enable    = ~i[1];
      bus.sum_x_in  = 29'(i * 1000);
      bus.sum_y_in  = 29'(i * 77);
      bus.count_in  = 19'(i + 1);
      #1;
      checks++;
      if ({bus.centro_x, bus.centro_y, bus.centro_valid,
           bus.busy, bus.frame_dropped, bus.acc_clear} !== '0) begin
        errors++;
        $display("FAIL reset_outs cyc%0d got x=%0d y=%0d v=%b b=%b d=%b c=%b want all 0",
          i, bus.centro_x, bus.centro_y, bus.centro_valid,
          bus.busy, bus.frame_dropped, bus.acc_clear);
      end
    end
    @(negedge clk);
    bus.frame_end = 1'b0;
    bus.enable    = 1'b1;
    rst_n         = 1'b1;
    step(2);
  endtask

  task automatic test_basic;
    pulse_frame(29'd3200, 29'd2400, 19'd10);
    checks++;
    if (bus.acc_clear !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_t1 got clr=%b busy=%b want 1 1",
        bus.acc_clear, bus.busy);
    end
    step(1);
    checks++;
    if (bus.acc_clear !== 1'b0) begin
      errors++;
      $display("FAIL basic_t2_clr got %b want 0", bus.acc_clear);
    end
    step(56);
    checks++;
    if (bus.centro_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_t58 got v=%b busy=%b want 0 1",
        bus.centro_valid, bus.busy);
    end
    step(1);
    checks++;
    if (bus.centro_valid !== 1'b1 || bus.busy !== 1'b1 ||
        bus.centro_x !== 10'd320 || bus.centro_y !== 10'd240) begin
      errors++;
      $display("FAIL basic_t59 got v=%b b=%b x=%0d y=%0d want 1 1 320 240",
        bus.centro_valid, bus.busy, bus.centro_x, bus.centro_y);
    end
    step(1);
    checks++;
    if (bus.centro_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.centro_x !== 10'd320) begin
      errors++;
      $display("FAIL basic_t60 got v=%b b=%b x=%0d want 0 0 320",
        bus.centro_valid, bus.busy, bus.centro_x);
    end
  endtask

  task automatic test_zero_count;
    int nv;
    int nb;
    nv = 0;
    nb = 0;
    pulse_frame(29'd5000, 29'd5000, 19'd0);
    checks++;
    if (bus.acc_clear !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_t1 got clr=%b busy=%b want 1 0",
        bus.acc_clear, bus.busy);
    end
    for (int i = 0; i < 70; i++) begin
      step(1);
      if (bus.centro_valid === 1'b1) nv++;
      if (bus.busy === 1'b1) nb++;
    end
    checks++;
    if (nv != 0 || nb != 0) begin
      errors++;
      $display("FAIL zero_novalid got valids=%0d busy=%0d want 0 0", nv, nb);
    end
    checks++;
    if (bus.centro_x !== 10'd320 || bus.centro_y !== 10'd240) begin
      errors++;
      $display("FAIL zero_hold got %0d,%0d want 320,240",
        bus.centro_x, bus.centro_y);
    end
  endtask

  task automatic test_drop;
    pulse_frame(29'd3300, 29'd2500, 19'd10);
    step(19);
    bus.sum_x_in  = 29'd100;
    bus.sum_y_in  = 29'd100;
    bus.count_in  = 19'd1;
    bus.frame_end = 1'b1;
    step(1);
    bus.frame_end = 1'b0;
    checks++;
    if (bus.frame_dropped !== 1'b1 || bus.acc_clear !== 1'b1 ||
        bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_t21 got d=%b c=%b b=%b want 1 1 1",
        bus.frame_dropped, bus.acc_clear, bus.busy);
    end
    step(1);
    checks++;
    if (bus.frame_dropped !== 1'b0) begin
      errors++;
      $display("FAIL drop_t22 got %b want 0", bus.frame_dropped);
    end
    step(37);
    checks++;
    if (bus.centro_valid !== 1'b1 || bus.centro_x !== 10'd330 ||
        bus.centro_y !== 10'd250) begin
      errors++;
      $display("FAIL drop_t59 got v=%b x=%0d y=%0d want 1 330 250",
        bus.centro_valid, bus.centro_x, bus.centro_y);
    end
    bus.frame_end = 1'b1;
    step(1);
    bus.frame_end = 1'b0;
    checks++;
    if (bus.frame_dropped !== 1'b1 || bus.busy !== 1'b0 ||
        bus.centro_x !== 10'd330) begin
      errors++;
      $display("FAIL drop_publish got d=%b b=%b x=%0d want 1 0 330",
        bus.frame_dropped, bus.busy, bus.centro_x);
    end
    step(1);
    checks++;
    if (bus.frame_dropped !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_after got d=%b b=%b want 0 0",
        bus.frame_dropped, bus.busy);
    end
  endtask

  task automatic test_round_sat;
    logic [28:0] sx [4];
    logic [28:0] sy [4];
    logic [18:0] cn [4];
    logic [9:0]  ex [4];
    logic [9:0]  ey [4];
    sx = '{29'd7, 29'h1FFF_FFFF, 29'd2048, 29'd3069};
    sy = '{29'd5, 29'd500,       29'd1023, 29'd1};
    cn = '{19'd2, 19'd1,         19'd2,    19'd3};
`ifdef CENTROID_ROUND_EN
    ex = '{10'd4, 10'd1023, 10'd1023, 10'd1023};
    ey = '{10'd3, 10'd500,  10'd512,  10'd0};
`else
    ex = '{10'd3, 10'd1023, 10'd1023, 10'd1023};
    ey = '{10'd2, 10'd500,  10'd511,  10'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      pulse_frame(sx[i], sy[i], cn[i]);
      step(58);
      checks++;
      if (bus.centro_valid !== 1'b1 || bus.centro_x !== ex[i] ||
          bus.centro_y !== ey[i]) begin
        errors++;
        $display("FAIL round_sat%0d got v=%b x=%0d y=%0d want 1 %0d %0d",
          i, bus.centro_valid, bus.centro_x, bus.centro_y, ex[i], ey[i]);
      end
      step(1);
    end
  endtask

  task automatic test_enable;
    int nv;
    nv = 0;
    pulse_frame(29'd3200, 29'd2400, 19'd10);
    step(29);
    bus.enable = 1'b0;
    step(1);
    checks++;
    if (bus.busy !== 1'b0 || bus.centro_valid !== 1'b0 ||
        bus.acc_clear !== 1'b1 || bus.centro_x !== 10'd0 ||
        bus.centro_y !== 10'd0 || bus.frame_dropped !== 1'b0) begin
      errors++;
      $display("FAIL en_low got b=%b v=%b c=%b x=%0d y=%0d d=%b want 0 0 1 0 0 0",
        bus.busy, bus.centro_valid, bus.acc_clear,
        bus.centro_x, bus.centro_y, bus.frame_dropped);
    end
    bus.frame_end = 1'b1;
    step(1);
    bus.frame_end = 1'b0;
    checks++;
    if (bus.frame_dropped !== 1'b0 || bus.busy !== 1'b0 ||
        bus.acc_clear !== 1'b1) begin
      errors++;
      $display("FAIL en_ignore_fe got d=%b b=%b c=%b want 0 0 1",
        bus.frame_dropped, bus.busy, bus.acc_clear);
    end
    bus.enable = 1'b1;
    step(1);
    checks++;
    if (bus.acc_clear !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL en_resume got c=%b b=%b want 0 0",
        bus.acc_clear, bus.busy);
    end
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.centro_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL en_novalid got %0d want 0", nv);
    end
  endtask

  task automatic test_rst_mid;
    int nv;
    nv = 0;
    pulse_frame(29'd1000, 29'd2000, 19'd10);
    step(58);
    checks++;
    if (bus.centro_valid !== 1'b1 || bus.centro_x !== 10'd100 ||
        bus.centro_y !== 10'd200) begin
      errors++;
      $display("FAIL rst_pre got v=%b x=%0d y=%0d want 1 100 200",
        bus.centro_valid, bus.centro_x, bus.centro_y);
    end
    step(1);
    pulse_frame(29'd3200, 29'd2400, 19'd10);
    step(29);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.centro_x !== 10'd0 ||
        bus.centro_y !== 10'd0 || bus.centro_valid !== 1'b0 ||
        bus.acc_clear !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got b=%b x=%0d y=%0d v=%b c=%b want 0 0 0 0 0",
        bus.busy, bus.centro_x, bus.centro_y,
        bus.centro_valid, bus.acc_clear);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus.centro_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_novalid got valids=%0d busy=%b want 0 0",
        nv, bus.busy);
    end
    pulse_frame(29'd3200, 29'd2400, 19'd10);
    step(58);
    checks++;
    if (bus.centro_valid !== 1'b1 || bus.centro_x !== 10'd320 ||
        bus.centro_y !== 10'd240) begin
      errors++;
      $display("FAIL rst_recover got v=%b x=%0d y=%0d want 1 320 240",
        bus.centro_valid, bus.centro_x, bus.centro_y);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.frame_end = 1'b0;
    bus.sum_x_in  = '0;
    bus.sum_y_in  = '0;
    bus.count_in  = '0;
    test_reset();
    test_basic();
    test_zero_count();
    test_drop();
    test_round_sat();
    test_enable();
    test_rst_mid();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
